sample_tick_gen: RTL and testbench

- Converts the 32-bit period word from the speed controller into the audio sample-rate timebase.
- Produces a one-cycle sample strobe, a 50% divided clock and a request/acknowledge handshake toward the flash/audio reader.
- Applies period changes only at period boundaries so output spacing never glitches, and flags samples the consumer failed to take in time.

---
 rtl/sample_tick_if.sv | 25 ++
 rtl/sample_tick_gen.sv | 110 +++++++++++
 tb/tb_sample_tick_gen.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_tick_if.sv
// sample_tick_if: speed-controller and sample-consumer signals of the sample tick generator.
// The slave modport is the generator; the master modport is its environment.
interface sample_tick_if;
    logic [31:0] div;
    logic        en;
    logic        ack;
    logic        ovr_clr;
    logic        tick;
    logic        clk_out;
    logic        req;
    logic        overrun;
    logic [31:0] active_div;
    logic [15:0] tick_cnt;
    logic [7:0]  ovr_cnt;

    modport master (
        output div, en, ack, ovr_clr,
        input  tick, clk_out, req, overrun, active_div, tick_cnt, ovr_cnt
    );

    modport slave (
        input  div, en, ack, ovr_clr,
        output tick, clk_out, req, overrun, active_div, tick_cnt, ovr_cnt
    );
endinterface

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: turns the speed-controller period word into a sample tick, a 50% divided clock
// and a req/ack handshake. Define SAMPLE_TICK_OVR_CNT_EN to build the saturating overrun counter.
module sample_tick_gen #(
    parameter logic [31:0] DIV_RESET = 32'h0000_0D90,
    parameter logic [31:0] DIV_MIN   = 32'd16,
    parameter logic [31:0] DIV_MAX   = 32'h0001_0000
) (
    input  logic         clk50M,
    input  logic         rst_n,
    sample_tick_if.slave bus
);
    localparam int unsigned DIV_W  = 32;
    localparam int unsigned TCNT_W = 16;
    localparam int unsigned OCNT_W = 8;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] x);
        if (x < DIV_MIN)      return DIV_MIN;
        else if (x > DIV_MAX) return DIV_MAX;
        else                  return x;
    endfunction

    localparam logic [DIV_W-1:0] DIV_RESET_CL = clamp_div(DIV_RESET);

    logic [DIV_W-1:0]  r_cnt;
    logic [DIV_W-1:0]  r_active_div;
    logic              r_tick;
    logic              r_clk_out;
    logic              r_req;
    logic              r_overrun;
    logic [TCNT_W-1:0] r_tick_cnt;

    logic [DIV_W-1:0]  w_div_clamped;
    logic              w_wrap;
    logic              w_ovr_evt;

    // w_wrap is the period boundary; tick, req and clk_out all become visible on the edge after it
    assign w_div_clamped = clamp_div(bus.div);
    assign w_wrap        = bus.en && (r_cnt == r_active_div - DIV_W'(1));
    assign w_ovr_evt     = w_wrap && r_req && !bus.ack;

    // Timebase: period changes are only taken at a boundary or while idle
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_active_div <= DIV_RESET_CL;
            r_tick       <= 1'b0;
            r_clk_out    <= 1'b0;
            r_tick_cnt   <= '0;
        end else begin
            r_tick <= w_wrap;
            if (!bus.en) begin
                r_cnt        <= '0;
                r_active_div <= w_div_clamped;
            end else if (w_wrap) begin
                r_cnt        <= '0;
                r_active_div <= w_div_clamped;
                r_clk_out    <= ~r_clk_out;
                r_tick_cnt   <= r_tick_cnt + TCNT_W'(1);
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
        end
    end

    // Handshake: a new tick always re-arms req, even if ack arrives on the same edge
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            r_req     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wrap)
                r_req <= 1'b1;
            else if (bus.ack && r_req)
                r_req <= 1'b0;

            if (w_ovr_evt)
                r_overrun <= 1'b1;
            else if (bus.ovr_clr)
                r_overrun <= 1'b0;
        end
    end

`ifdef SAMPLE_TICK_OVR_CNT_EN
    logic [OCNT_W-1:0] r_ovr_cnt;

    // Saturating count of missed samples; a same-cycle event beats the clear
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_cnt <= '0;
        end else if (w_ovr_evt) begin
            if (r_ovr_cnt != {OCNT_W{1'b1}})
                r_ovr_cnt <= r_ovr_cnt + OCNT_W'(1);
        end else if (bus.ovr_clr) begin
            r_ovr_cnt <= '0;
        end
    end

    assign bus.ovr_cnt = r_ovr_cnt;
`else
    assign bus.ovr_cnt = OCNT_W'(0);
`endif

    assign bus.tick       = r_tick;
    assign bus.clk_out    = r_clk_out;
    assign bus.req        = r_req;
    assign bus.overrun    = r_overrun;
    assign bus.active_div = r_active_div;
    assign bus.tick_cnt   = r_tick_cnt;

endmodule

// File: tb/tb_sample_tick_gen.sv
// tb_sample_tick_gen: scoreboard bench for sample_tick_gen; expectations are queued as stimulus is
// applied and compared against DUT observations in each scenario task.
module tb_sample_tick_gen;
    logic clk50M = 1'b0;
    logic rst_n  = 1'b0;

    sample_tick_if bus ();

    sample_tick_gen #(
        .DIV_RESET (32'h0000_0D90),
        .DIV_MIN   (32'd16),
        .DIV_MAX   (32'h0001_0000)
    ) dut (
        .clk50M (clk50M),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk50M = ~clk50M;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    function automatic logic [31:0] model_clamp(input logic [31:0] x);
        if (x < 32'd16)                return 32'd16;
        else if (x > 32'h0001_0000)    return 32'h0001_0000;
        else                           return x;
    endfunction

    function automatic logic [31:0] exp_ovr(input int n);
`ifdef SAMPLE_TICK_OVR_CNT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic push(input string n, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // Counts falling edges until tick is seen high, giving up after budget edges
    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk50M);
            n++;
        end while (bus.tick !== 1'b1 && n < budget);
    endtask

    task automatic do_reset();
        @(negedge clk50M);
        rst_n       = 1'b0;
        bus.en      = 1'b0;
        bus.ack     = 1'b0;
        bus.ovr_clr = 1'b0;
        repeat (2) @(negedge clk50M);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] obs[$];
        @(negedge clk50M);
        push("rst_tick", 32'd0);            obs.push_back(32'(bus.tick));
        push("rst_clk_out", 32'd0);         obs.push_back(32'(bus.clk_out));
        push("rst_req", 32'd0);             obs.push_back(32'(bus.req));
        push("rst_overrun", 32'd0);         obs.push_back(32'(bus.overrun));
        push("rst_tick_cnt", 32'd0);        obs.push_back(32'(bus.tick_cnt));
        push("rst_ovr_cnt", 32'd0);         obs.push_back(32'(bus.ovr_cnt));
        push("rst_active_div", 32'h0D90);   obs.push_back(bus.active_div);
        foreach (obs[i]) begin
            exp_t e;
            e = sb.pop_front();
            total_cnt++;
            if (obs[i] !== e.exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, obs[i], e.exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_default_period();
        logic [31:0] obs[$];
        int n;
        bus.div = 32'h0D90;
        rst_n   = 1'b1;
        repeat (2) @(negedge clk50M);
        bus.en = 1'b1;
        push("first_tick_latency", 32'd3472);
        wait_tick(3472 + 64, n);                obs.push_back(32'(n));
        push("tick_cnt_first", 32'd1);          obs.push_back(32'(bus.tick_cnt));
        push("req_with_tick", 32'd1);           obs.push_back(32'(bus.req));
        push("clk_out_first", 32'd1);           obs.push_back(32'(bus.clk_out));
        push("active_div_default", 32'h0D90);   obs.push_back(bus.active_div);
        bus.ack = 1'b1;
        @(negedge clk50M);
        bus.ack = 1'b0;
        push("tick_width", 32'd0);              obs.push_back(32'(bus.tick));
        @(negedge clk50M);
        push("req_after_ack", 32'd0);           obs.push_back(32'(bus.req));
        push("tick_spacing", 32'd3472);
        wait_tick(3472 + 64, n);                obs.push_back(32'(n + 2));
        push("clk_out_second", 32'd0);          obs.push_back(32'(bus.clk_out));
        push("tick_cnt_second", 32'd2);         obs.push_back(32'(bus.tick_cnt));
        push("overrun_none", 32'd0);            obs.push_back(32'(bus.overrun));
        foreach (obs[i]) begin
            exp_t e;
            e = sb.pop_front();
            total_cnt++;
            if (obs[i] !== e.exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, obs[i], e.exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_midperiod_change();
        logic [31:0] obs[$];
        int n;
        do_reset();
        bus.div = 32'd20;
        repeat (2) @(negedge clk50M);
        bus.en = 1'b1;
        repeat (5) @(negedge clk50M);
        bus.div = 32'd40;
        repeat (5) @(negedge clk50M);
        push("active_div_midperiod", 32'd20);   obs.push_back(bus.active_div);
        push("period_before_change", 32'd20);
        wait_tick(20 + 64, n);                  obs.push_back(32'(n + 10));
        push("active_div_after_change", 32'd40); obs.push_back(bus.active_div);
        push("period_after_change", 32'd40);
        wait_tick(40 + 64, n);                  obs.push_back(32'(n));
        bus.en = 1'b0;
        foreach (obs[i]) begin
            exp_t e;
            e = sb.pop_front();
            total_cnt++;
            if (obs[i] !== e.exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, obs[i], e.exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_clamp();
        logic [31:0] obs[$];
        logic [31:0] vals[8];
        int n;
        vals = '{32'd3, 32'd15, 32'd16, 32'd17, 32'h0001_0000, 32'h0001_0001, 32'h0002_0000, 32'd0};
        do_reset();
        foreach (vals[i]) begin
            bus.div = vals[i];
            push($sformatf("clamp_div_%0h", vals[i]), model_clamp(vals[i]));
            @(negedge clk50M);
            obs.push_back(bus.active_div);
        end
        bus.div = 32'd3;
        @(negedge clk50M);
        bus.en = 1'b1;
        push("clamped_first_tick", 32'd16);
        wait_tick(16 + 64, n);                  obs.push_back(32'(n));
        push("clamped_period", 32'd16);
        wait_tick(16 + 64, n);                  obs.push_back(32'(n));
        bus.en = 1'b0;
        foreach (obs[i]) begin
            exp_t e;
            e = sb.pop_front();
            total_cnt++;
            if (obs[i] !== e.exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, obs[i], e.exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_overrun();
        logic [31:0] obs[$];
        int n;
        do_reset();
        bus.div = 32'd16;
        repeat (2) @(negedge clk50M);
        bus.en = 1'b1;
        push("ovr_tick1_period", 32'd16);
        wait_tick(16 + 64, n);                  obs.push_back(32'(n));
        push("ovr_tick1_req", 32'd1);           obs.push_back(32'(bus.req));
        push("ovr_tick1_overrun", 32'd0);       obs.push_back(32'(bus.overrun));
        push("ovr_tick1_cnt", exp_ovr(0));      obs.push_back(32'(bus.ovr_cnt));
        wait_tick(16 + 64, n);
        push("ovr_tick2_overrun", 32'd1);       obs.push_back(32'(bus.overrun));
        push("ovr_tick2_cnt", exp_ovr(1));      obs.push_back(32'(bus.ovr_cnt));
        wait_tick(16 + 64, n);
        push("ovr_tick3_cnt", exp_ovr(2));      obs.push_back(32'(bus.ovr_cnt));
        repeat (15) @(negedge clk50M);
        bus.ovr_clr = 1'b1;
        @(negedge clk50M);
        bus.ovr_clr = 1'b0;
        push("ovr_clr_tick_seen", 32'd1);       obs.push_back(32'(bus.tick));
        push("ovr_clr_on_tick_flag", 32'd1);    obs.push_back(32'(bus.overrun));
        push("ovr_clr_on_tick_cnt", exp_ovr(3)); obs.push_back(32'(bus.ovr_cnt));
        bus.ovr_clr = 1'b1;
        @(negedge clk50M);
        bus.ovr_clr = 1'b0;
        push("ovr_clr_flag", 32'd0);            obs.push_back(32'(bus.overrun));
        push("ovr_clr_cnt", 32'd0);             obs.push_back(32'(bus.ovr_cnt));
        push("ovr_clr_req_kept", 32'd1);        obs.push_back(32'(bus.req));
        bus.en = 1'b0;
        foreach (obs[i]) begin
            exp_t e;
            e = sb.pop_front();
            total_cnt++;
            if (obs[i] !== e.exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, obs[i], e.exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_ack_on_tick();
        logic [31:0] obs[$];
        int n;
        do_reset();
        bus.div = 32'd16;
        repeat (2) @(negedge clk50M);
        bus.en = 1'b1;
        wait_tick(16 + 64, n);
        push("ack_pre_req", 32'd1);             obs.push_back(32'(bus.req));
        // ack sampled on the same edge that registers the next tick
        repeat (15) @(negedge clk50M);
        bus.ack = 1'b1;
        @(negedge clk50M);
        bus.ack = 1'b0;
        push("ack_tick_seen", 32'd1);           obs.push_back(32'(bus.tick));
        push("ack_tick_req", 32'd1);            obs.push_back(32'(bus.req));
        push("ack_tick_overrun", 32'd0);        obs.push_back(32'(bus.overrun));
        repeat (3) @(negedge clk50M);
        bus.ack = 1'b1;
        @(negedge clk50M);
        bus.ack = 1'b0;
        push("ack_plain_req", 32'd0);           obs.push_back(32'(bus.req));
        push("ack_next_period", 32'd16);
        wait_tick(16 + 64, n);                  obs.push_back(32'(n + 4));
        push("ack_next_overrun", 32'd0);        obs.push_back(32'(bus.overrun));
        push("ack_next_req", 32'd1);            obs.push_back(32'(bus.req));
        bus.en = 1'b0;
        foreach (obs[i]) begin
            exp_t e;
            e = sb.pop_front();
            total_cnt++;
            if (obs[i] !== e.exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, obs[i], e.exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midperiod();
        logic [31:0] obs[$];
        int n;
        do_reset();
        bus.div = 32'd16;
        repeat (2) @(negedge clk50M);
        bus.en = 1'b1;
        wait_tick(16 + 64, n);
        push("pre_rst_tick_cnt", 32'd1);        obs.push_back(32'(bus.tick_cnt));
        repeat (10) @(negedge clk50M);
        #2;
        rst_n   = 1'b0;
        bus.div = 32'h0D90;
        #1;
        push("async_rst_tick_cnt", 32'd0);      obs.push_back(32'(bus.tick_cnt));
        push("async_rst_req", 32'd0);           obs.push_back(32'(bus.req));
        push("async_rst_clk_out", 32'd0);       obs.push_back(32'(bus.clk_out));
        push("async_rst_active_div", 32'h0D90); obs.push_back(bus.active_div);
        repeat (2) @(negedge clk50M);
        rst_n = 1'b1;
        push("post_rst_first_tick", 32'd3472);
        wait_tick(3472 + 64, n);                obs.push_back(32'(n));
        push("post_rst_tick_cnt", 32'd1);       obs.push_back(32'(bus.tick_cnt));
        bus.en = 1'b0;
        foreach (obs[i]) begin
            exp_t e;
            e = sb.pop_front();
            total_cnt++;
            if (obs[i] !== e.exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, obs[i], e.exp);
            else pass_cnt++;
        end
    endtask

    initial begin
        bus.div     = 32'd3;
        bus.en      = 1'b0;
        bus.ack     = 1'b0;
        bus.ovr_clr = 1'b0;
        test_reset();
        test_default_period();
        test_midperiod_change();
        test_clamp();
        test_overrun();
        test_ack_on_tick();
        test_reset_midperiod();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d so far", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
